// File: rtl/ps_readout_sequencer.sv
// Readout sequencer: pulses the parallel-to-serial capture block on a period, then drains its FIFO to a valid/ready stream.
// Optional build macro PS_SEQ_HEADER_EN prepends a {4'hA, frame_cnt, ts} header word to each frame (needs FIFO_WIDTH==36).
module ps_readout_sequencer #(
  parameter int FIFO_WIDTH      = 36,
  parameter int NDATA           = 10,
  parameter int PERIOD_WIDTH    = 16,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk_in,
  input  logic                       rst,
  input  logic                       run,
  input  logic                       single,
  input  logic [PERIOD_WIDTH-1:0]    period,
  input  logic [FRAME_CNT_WIDTH-1:0] nframes,
  input  logic                       mode_cfg,
  output logic                       ps_start,
  output logic                       ps_mode,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0]      fifo_q,
  output logic [FIFO_WIDTH-1:0]      m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       busy,
  output logic                       done,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
  output logic                       overrun
);

  // Output handshake: a word transfers on any rising edge where m_valid && m_ready;
  // m_data/m_valid never change while m_valid is high and m_ready is low.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_START   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DRAIN   = 3'd4,
    S_WAIT    = 3'd5
  } state_t;

  localparam int                CAP_W    = $clog2(NDATA + 3);
  localparam logic [CAP_W-1:0]  CAP_LAST = CAP_W'(NDATA + 1);

  state_t                     state;
  state_t                     state_nxt;
  logic                       single_req;
  logic                       single_flag;
  logic [FRAME_CNT_WIDTH-1:0] nframes_q;
  logic [PERIOD_WIDTH-1:0]    period_q;
  logic [PERIOD_WIDTH-1:0]    pcnt;
  logic [CAP_W-1:0]           cap_cnt;
  logic                       rd_pend;

  logic rd_go;
  logic drain_done;
  logic last_frame;
  logic period_hit;
  logic period_late;

`ifdef PS_SEQ_HEADER_EN
  logic [15:0] ts_cnt;
  logic [15:0] ts_q;
  logic [35:0] hdr_word;

  assign hdr_word = {4'hA, frame_cnt[15:0], ts_q};

  always_ff @(posedge clk_in) begin
    if (rst) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
      if (state == S_START) ts_q <= ts_cnt;
    end
  end
`endif

  // pcnt holds the number of cycles elapsed since the last START cycle.
  always_comb begin
    rd_go       = (state == S_DRAIN) && !fifo_empty && !rd_pend && (!m_valid || m_ready);
    drain_done  = fifo_empty && !rd_pend && !m_valid;
    last_frame  = single_flag || !run || ((nframes_q != '0) && (frame_cnt == nframes_q));
    period_late = (pcnt >= period_q);
    period_hit  = (pcnt >= (period_q - PERIOD_WIDTH'(1)));
    state_nxt   = state;
    case (state)
      S_IDLE:    if (run || single) state_nxt = S_ARM;
      S_ARM:     state_nxt = S_START;
      S_START:   state_nxt = S_CAPTURE;
      S_CAPTURE: if (cap_cnt == CAP_LAST) state_nxt = S_DRAIN;
      S_DRAIN:   if (drain_done) state_nxt = last_frame ? S_IDLE : S_WAIT;
      S_WAIT:    if (period_hit) state_nxt = S_START;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign ps_start   = (state == S_START);
  assign busy       = (state != S_IDLE);
  assign fifo_rd_en = rd_go;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      single_req  <= 1'b0;
      single_flag <= 1'b0;
      nframes_q   <= '0;
      period_q    <= PERIOD_WIDTH'(1);
      pcnt        <= '0;
      cap_cnt     <= '0;
      rd_pend     <= 1'b0;
      ps_mode     <= 1'b0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
      done        <= 1'b0;
    end else begin
      done    <= (state == S_DRAIN) && (state_nxt == S_IDLE);
      rd_pend <= rd_go;

      // run has priority, so a simultaneous single still gives an open-ended run.
      if (state == S_IDLE) single_req <= single && !run;

      if (state == S_ARM) begin
        single_flag <= single_req;
        ps_mode     <= mode_cfg;
        nframes_q   <= nframes;
        period_q    <= (period == '0) ? PERIOD_WIDTH'(1) : period;
        frame_cnt   <= '0;
        overrun     <= 1'b0;
      end

      if (state == S_START) begin
        frame_cnt <= frame_cnt + FRAME_CNT_WIDTH'(1);
        cap_cnt   <= '0;
      end else if (state == S_CAPTURE) begin
        cap_cnt <= cap_cnt + CAP_W'(1);
      end

      // Saturate so a very long drain cannot wrap back into "not yet expired".
      if (state == S_START) begin
        pcnt <= PERIOD_WIDTH'(1);
      end else if (pcnt != '1) begin
        pcnt <= pcnt + PERIOD_WIDTH'(1);
      end

      if ((state == S_WAIT) && period_late) overrun <= 1'b1;
    end
  end

  // Output register: a pending FIFO read always lands in an empty or just-emptied slot.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      if (rd_pend) begin
        m_data  <= fifo_q;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
`ifdef PS_SEQ_HEADER_EN
      if ((state == S_CAPTURE) && (state_nxt == S_DRAIN)) begin
        m_data  <= FIFO_WIDTH'(hdr_word);
        m_valid <= 1'b1;
      end
`endif
    end
  end

endmodule
